// File: rtl/updown_judge.sv
// updown_judge: up/down number-guessing game controller.
// Draws a secret target in 1..99 from an external pseudo-random source by
// rejection sampling, scores player guesses with up/down/correct hints,
// counts tries and declares a win or a loss.
module updown_judge #(
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] random,
  input  logic       start,
  input  logic       guess_valid,
  input  logic [6:0] guess,
  output logic       busy,
  output logic       result_valid,
  output logic       hint_up,
  output logic       hint_down,
  output logic       correct,
  output logic       invalid,
  output logic [3:0] tries,
  output logic       won,
  output logic       lost,
  output logic [6:0] target
);

  localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);
  localparam logic [6:0] VALUE_MAX   = 7'd99;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    PLAY,
    WIN,
    LOSE
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] target_q, target_d;
  logic [3:0] tries_q, tries_d;
  logic       rv_q, rv_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       correct_q, correct_d;
  logic       invalid_q, invalid_d;

  logic       random_ok;
  logic       guess_ok;
  logic [3:0] tries_inc;

  assign random_ok = (random != '0) && (random <= VALUE_MAX);
  assign guess_ok  = (guess != '0) && (guess <= VALUE_MAX);
  assign tries_inc = tries_q + 4'd1;

  // State register and all registered game outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      tries_q   <= '0;
      rv_q      <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      correct_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      tries_q   <= tries_d;
      rv_q      <= rv_d;
      up_q      <= up_d;
      down_q    <= down_d;
      correct_q <= correct_d;
      invalid_q <= invalid_d;
    end
  end

  // Next-state and next-output logic; hints and tries hold unless updated.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    tries_d   = tries_q;
    rv_d      = 1'b0;
    up_d      = up_q;
    down_d    = down_q;
    correct_d = correct_q;
    invalid_d = invalid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRAW;
          target_d  = '0;
          tries_d   = '0;
          up_d      = 1'b0;
          down_d    = 1'b0;
          correct_d = 1'b0;
          invalid_d = 1'b0;
        end
      end

      DRAW: begin
        // Out-of-range samples are simply retried next cycle.
        if (random_ok) begin
          state_d  = PLAY;
          target_d = random;
          tries_d  = '0;
        end
      end

      PLAY: begin
        if (guess_valid) begin
          rv_d = 1'b1;
          if (!guess_ok) begin
            invalid_d = 1'b1;
            up_d      = 1'b0;
            down_d    = 1'b0;
            correct_d = 1'b0;
          end else begin
            invalid_d = 1'b0;
            tries_d   = tries_inc;
            up_d      = (guess < target_q);
            down_d    = (guess > target_q);
            correct_d = (guess == target_q);
            if (guess == target_q) begin
              state_d = WIN;
            end else if (tries_inc == TRIES_LIMIT) begin
              state_d = LOSE;
            end
          end
        end
      end

      WIN, LOSE: begin
        if (start) begin
          state_d   = DRAW;
          target_d  = '0;
          tries_d   = '0;
          up_d      = 1'b0;
          down_d    = 1'b0;
          correct_d = 1'b0;
          invalid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q == DRAW) || (state_q == PLAY);
  assign won          = (state_q == WIN);
  assign lost         = (state_q == LOSE);
  assign target       = (won || lost) ? target_q : '0;
  assign result_valid = rv_q;
  assign hint_up      = up_q;
  assign hint_down    = down_q;
  assign correct      = correct_q;
  assign invalid      = invalid_q;
  assign tries        = tries_q;

endmodule

// File: doc/updown_judge.md
# updown_judge

Game-logic block for the up/down number-guessing game. It consumes the 7-bit output of the pseudo-random generator and draws a secret target in the range 1..99. It then accepts player guesses and answers each one with up, down or correct hints. It tracks the number of tries and declares win or loss. It sits between the random source and the display/input front end.

## Interface

- MAX_TRIES, default 7: wrong guesses allowed before a loss (1..15).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- random  input  7  free-running pseudo-random value; sampled only in DRAW.
- start  input  1  single-cycle request to begin a new game.
- guess_valid  input  1  qualifies guess for one cycle.
- guess  input  7  player guess, unsigned.
- busy  output  1  high in DRAW and PLAY.
- result_valid  output  1  one-cycle pulse: hint/correct/invalid outputs updated this cycle.
- hint_up  output  1  last accepted guess < target (player must go up).
- hint_down  output  1  last accepted guess > target.
- correct  output  1  last accepted guess == target.
- invalid  output  1  last presented guess was outside 1..99; not counted.
- tries  output  4  count of counted guesses in the current game.
- won  output  1  level, high in WIN.
- lost  output  1  level, high in LOSE.
- target  output  7  secret value; driven only in WIN/LOSE, otherwise 0.

## Operation

- States: IDLE, DRAW, PLAY, WIN, LOSE. Reset enters IDLE.
- IDLE: start -> DRAW. guess_valid is ignored.
- DRAW: each cycle, sample random.
  - If 1 <= random <= 99: latch it into the internal target register, clear tries, and go to PLAY.
  - Otherwise stay in DRAW and retry next cycle (rejection sampling, no modulo).
- PLAY, on guess_valid:
  - guess is 0 or > 99: invalid=1; hint_up, hint_down and correct are cleared; tries is unchanged; stay in PLAY.
  - guess == target: correct=1, tries+1, go to WIN.
  - guess < target: hint_up=1, tries+1.
  - guess > target: hint_down=1, tries+1.
  - A wrong guess that brings tries to MAX_TRIES goes to LOSE, with its hint still reported.
  - At most one of hint_up, hint_down, correct, invalid is high at a time.
- WIN/LOSE: won or lost is held. target shows the latched value. guess_valid is ignored. start -> DRAW.
- Entering DRAW clears hint_up, hint_down, correct, invalid, tries, won, lost and target.
- start while in DRAW or PLAY is ignored, including when it coincides with guess_valid in PLAY; the guess is still processed.
- tries is 4 bits and never exceeds MAX_TRIES, so it never wraps.

## Timing

- Reset values: every output is 0 and the state is IDLE.
- start sampled at edge N puts the block in DRAW at N+1. busy is registered and high from that cycle.
- DRAW latency: if random is in range at the first DRAW edge, the state is PLAY one cycle later. Each rejected sample adds one cycle.
- guess_valid sampled at edge N:
  - result_valid pulses and the hint/correct/invalid/tries/won/lost updates are visible after edge N (registered, latency 1).
  - Consecutive guess_valid cycles are each processed; throughput is one guess per cycle.
  - A guess arriving in the cycle the block enters WIN/LOSE is ignored, with no result_valid.
- Hint outputs are level-held until the next accepted guess or the next DRAW entry.
- reset in any state, including mid-DRAW or mid-PLAY, wins over all other inputs at that edge.

## Test plan

- Reset then idle: assert reset 2 cycles. All outputs are 0. guess_valid with guess=50 gives no result_valid and tries=0.
- Rejection sampling: start while random=0, then 120, then 42. The block stays in DRAW 2 cycles and enters PLAY on the third. busy is high throughout DRAW and PLAY.
- Binary search win with target 42: guesses 50 -> hint_down, tries=1; 25 -> hint_up, tries=2; 42 -> correct, won=1, target=42, busy=0, tries=3.
- Invalid guesses with target 10: guess 0 then 100 -> invalid=1 both times, tries=0, hints cleared. Then guess 10 -> correct.
- Loss with MAX_TRIES=7 and target 99: seven guesses of 1 -> hint_up each, with tries rising to 7. lost=1 after the 7th, target=99. An 8th guess_valid gives no result_valid.
- Restart and reset mid-game:
  - After the loss, start with random=7 -> won, lost, tries and target clear; PLAY with target 7.
  - Guess 3 -> hint_up.
  - Reset asserted together with guess_valid -> IDLE, all outputs 0, no result_valid.
